// File: rtl/pipe_ctrl.sv
// Stall/flush controller: merges hazard, redirect and memory-wait requests into stage enables/bubbles.
// Enables/flushes are combinational this cycle (act on next edge); no backpressure beyond freezing stages.
module pipe_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_stall,
  input  logic             br_taken_ex,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             bubble_ma,
  output logic             mem_timeout,
  output logic             ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {RUN = 1'b0, DSTALL = 1'b1} state_e;
  typedef enum logic [2:0] {
    C_RST, C_DSTALL, C_BRANCH, C_LOADUSE, C_DROP, C_IWAIT, C_ADVANCE
  } sel_e;

  state_e            state_q;
  logic              redirect_pending_q, redirect_pending_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              bubble_ma_q;
  logic              mem_timeout_q;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              dstall;
  sel_e              sel;

  assign dstall = dmem_req && !dmem_ready;

  always_comb begin
    if (rst)                                   sel = C_RST;
    else if (dstall)                           sel = C_DSTALL;
    else if (br_taken_ex)                      sel = C_BRANCH;
    else if (load_use_stall)                   sel = C_LOADUSE;
    else if (redirect_pending_q && imem_ready) sel = C_DROP;
    else if (!imem_ready)                      sel = C_IWAIT;
    else                                       sel = C_ADVANCE;
  end

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    exmem_we    = 1'b1;
    memwb_we    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    case (sel)
      C_RST: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_we     = 1'b0;
        exmem_we    = 1'b0;
        memwb_we    = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        memwb_flush = 1'b1;
      end
      // Freeze everything up to EX/MEM; MEM/WB drains with a bubble.
      C_DSTALL: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_we     = 1'b0;
        exmem_we    = 1'b0;
        memwb_flush = 1'b1;
      end
      C_BRANCH: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      C_LOADUSE: begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_flush = 1'b1;
      end
      C_DROP, C_IWAIT: begin
        pc_we      = 1'b0;
        ifid_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    redirect_pending_d = redirect_pending_q;
    if (sel == C_BRANCH && !imem_ready) redirect_pending_d = 1'b1;
    else if (sel == C_DROP)             redirect_pending_d = 1'b0;

    stall_cnt_d = stall_cnt_q;
    if (!pc_we && !rst && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);

    flush_cnt_d = flush_cnt_q;
    if (sel == C_BRANCH && flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= RUN;
      redirect_pending_q <= 1'b0;
      wait_cnt_q         <= '0;
      bubble_ma_q        <= 1'b0;
      mem_timeout_q      <= 1'b0;
      stall_cnt_q        <= '0;
      flush_cnt_q        <= '0;
    end else begin
      redirect_pending_q <= redirect_pending_d;
      bubble_ma_q        <= (sel == C_LOADUSE);
      stall_cnt_q        <= stall_cnt_d;
      flush_cnt_q        <= flush_cnt_d;
      case (state_q)
        RUN: begin
          if (dstall) begin
            state_q    <= DSTALL;
            wait_cnt_q <= '0;
          end
        end
        DSTALL: begin
          if (!dstall) begin
            state_q <= RUN;
          end else if (wait_cnt_q == WAIT_LAST) begin
            // Sticky; the pipeline keeps waiting on the memory regardless.
            mem_timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bubble_ma   = bubble_ma_q;
  assign mem_timeout = mem_timeout_q;
  assign ctrl_state  = state_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_pipe_ctrl;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst, load_use_stall, br_taken_ex, imem_ready, dmem_req, dmem_ready;
  logic pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic ifid_flush, idex_flush, memwb_flush;
  logic bubble_ma, mem_timeout, ctrl_state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  typedef struct packed {
    logic [4:0]       we;   // {pc, ifid, idex, exmem, memwb}
    logic [2:0]       fl;   // {ifid, idex, memwb}
    logic             bub;
    logic             mto;
    logic             st;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   vec_no = 0;

  pipe_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .load_use_stall(load_use_stall), .br_taken_ex(br_taken_ex), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we), .memwb_we(memwb_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
    .bubble_ma(bubble_ma), .mem_timeout(mem_timeout), .ctrl_state(ctrl_state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int vec, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, vec, act, exp);
    end
  endtask

  task automatic step(input logic r, lu, br, im, dq, dr,
                      input logic [4:0] we, input logic [2:0] fl,
                      input logic bub, mto, st, input logic [CNT_W-1:0] sc, fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; load_use_stall = lu; br_taken_ex = br;
    imem_ready = im; dmem_req = dq; dmem_ready = dr;
    e.we = we; e.fl = fl; e.bub = bub; e.mto = mto; e.st = st; e.sc = sc; e.fc = fc;
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vec_no++;
        check("we",          vec_no, {27'd0, pc_we, ifid_we, idex_we, exmem_we, memwb_we}, {27'd0, e.we});
        check("flush",       vec_no, {29'd0, ifid_flush, idex_flush, memwb_flush}, {29'd0, e.fl});
        check("bubble_ma",   vec_no, {31'd0, bubble_ma},   {31'd0, e.bub});
        check("mem_timeout", vec_no, {31'd0, mem_timeout}, {31'd0, e.mto});
        check("ctrl_state",  vec_no, {31'd0, ctrl_state},  {31'd0, e.st});
        check("stall_cnt",   vec_no, {28'd0, stall_cnt},   {28'd0, e.sc});
        check("flush_cnt",   vec_no, {28'd0, flush_cnt},   {28'd0, e.fc});
      end
    end
  end

  initial begin
    rst = 1'b1; load_use_stall = 1'b0; br_taken_ex = 1'b0;
    imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);

    //   rst lu br im dq dr   we        fl      bub mto st sc     fc
    // reset state and idle advance
    step(1, 0, 0, 1, 0, 0, 5'b00000, 3'b111, 0, 0, 0, 4'd0,  4'd0);  // 1
    step(0, 0, 0, 1, 0, 0, 5'b11111, 3'b000, 0, 0, 0, 4'd0,  4'd0);  // 2
    // load-use: one stall cycle, bubble in EX next cycle
    step(0, 1, 0, 1, 0, 0, 5'b00111, 3'b010, 0, 0, 0, 4'd0,  4'd0);  // 3
    step(0, 0, 0, 1, 0, 0, 5'b11111, 3'b000, 1, 0, 0, 4'd1,  4'd0);  // 4
    step(0, 0, 0, 1, 0, 0, 5'b11111, 3'b000, 0, 0, 0, 4'd1,  4'd0);  // 5
    // branch with ready fetch beats load-use; no pending redirect afterwards
    step(0, 1, 1, 1, 0, 0, 5'b11111, 3'b110, 0, 0, 0, 4'd1,  4'd0);  // 6
    step(0, 0, 0, 1, 0, 0, 5'b11111, 3'b000, 0, 0, 0, 4'd1,  4'd1);  // 7
    // branch with outstanding fetch, two waits, drop, then normal
    step(0, 0, 1, 0, 0, 0, 5'b11111, 3'b110, 0, 0, 0, 4'd1,  4'd1);  // 8
    step(0, 0, 0, 0, 0, 0, 5'b01111, 3'b100, 0, 0, 0, 4'd1,  4'd2);  // 9
    step(0, 0, 0, 0, 0, 0, 5'b01111, 3'b100, 0, 0, 0, 4'd2,  4'd2);  // 10
    step(0, 0, 0, 1, 0, 0, 5'b01111, 3'b100, 0, 0, 0, 4'd3,  4'd2);  // 11
    step(0, 0, 0, 1, 0, 0, 5'b11111, 3'b000, 0, 0, 0, 4'd4,  4'd2);  // 12
    // second redirect while pending keeps it set; one drop clears it
    step(0, 0, 1, 0, 0, 0, 5'b11111, 3'b110, 0, 0, 0, 4'd4,  4'd2);  // 13
    step(0, 0, 1, 0, 0, 0, 5'b11111, 3'b110, 0, 0, 0, 4'd4,  4'd3);  // 14
    step(0, 0, 0, 1, 0, 0, 5'b01111, 3'b100, 0, 0, 0, 4'd4,  4'd4);  // 15
    step(0, 0, 0, 1, 0, 0, 5'b11111, 3'b000, 0, 0, 0, 4'd5,  4'd4);  // 16
    // memory wait with branch and load-use held: freeze wins, branch fires on ready
    step(0, 1, 1, 1, 1, 0, 5'b00001, 3'b001, 0, 0, 0, 4'd5,  4'd4);  // 17
    step(0, 1, 1, 1, 1, 0, 5'b00001, 3'b001, 0, 0, 1, 4'd6,  4'd4);  // 18
    step(0, 1, 1, 1, 1, 0, 5'b00001, 3'b001, 0, 0, 1, 4'd7,  4'd4);  // 19
    step(0, 1, 1, 1, 1, 1, 5'b11111, 3'b110, 0, 0, 1, 4'd8,  4'd4);  // 20
    step(0, 0, 0, 1, 0, 0, 5'b11111, 3'b000, 0, 0, 0, 4'd8,  4'd5);  // 21
    // six-cycle data stall with MEM_TIMEOUT=4: sticky timeout
    step(0, 0, 0, 1, 1, 0, 5'b00001, 3'b001, 0, 0, 0, 4'd8,  4'd5);  // 22
    step(0, 0, 0, 1, 1, 0, 5'b00001, 3'b001, 0, 0, 1, 4'd9,  4'd5);  // 23
    step(0, 0, 0, 1, 1, 0, 5'b00001, 3'b001, 0, 0, 1, 4'd10, 4'd5);  // 24
    step(0, 0, 0, 1, 1, 0, 5'b00001, 3'b001, 0, 0, 1, 4'd11, 4'd5);  // 25
    step(0, 0, 0, 1, 1, 0, 5'b00001, 3'b001, 0, 0, 1, 4'd12, 4'd5);  // 26
    step(0, 0, 0, 1, 1, 0, 5'b00001, 3'b001, 0, 1, 1, 4'd13, 4'd5);  // 27
    step(0, 0, 0, 1, 0, 0, 5'b11111, 3'b000, 0, 1, 1, 4'd14, 4'd5);  // 28
    step(0, 0, 0, 1, 0, 0, 5'b11111, 3'b000, 0, 1, 0, 4'd14, 4'd5);  // 29
    // fetch waits drive stall_cnt into saturation
    step(0, 0, 0, 0, 0, 0, 5'b01111, 3'b100, 0, 1, 0, 4'd14, 4'd5);  // 30
    step(0, 0, 0, 0, 0, 0, 5'b01111, 3'b100, 0, 1, 0, 4'd15, 4'd5);  // 31
    step(0, 0, 0, 0, 0, 0, 5'b01111, 3'b100, 0, 1, 0, 4'd15, 4'd5);  // 32
    step(0, 0, 0, 1, 0, 0, 5'b11111, 3'b000, 0, 1, 0, 4'd15, 4'd5);  // 33
    // redirect pending + DSTALL, then reset clears everything
    step(0, 0, 1, 0, 0, 0, 5'b11111, 3'b110, 0, 1, 0, 4'd15, 4'd5);  // 34
    step(0, 0, 0, 0, 1, 0, 5'b00001, 3'b001, 0, 1, 0, 4'd15, 4'd6);  // 35
    step(1, 0, 1, 0, 1, 0, 5'b00000, 3'b111, 0, 1, 1, 4'd15, 4'd6);  // 36
    step(0, 0, 0, 1, 0, 0, 5'b11111, 3'b000, 0, 0, 0, 4'd0,  4'd0);  // 37
    step(0, 0, 0, 1, 0, 0, 5'b11111, 3'b000, 0, 0, 0, 4'd0,  4'd0);  // 38

    repeat (2) @(negedge clk);
    check("scoreboard_drained", vec_no, exp_q.size(), 32'd0);
    check("vectors_seen", vec_no, vec_no, 32'd38);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
